// File: rtl/hilo_muldiv_if.sv
// Decoder-facing bundle for the HI/LO multiply/divide unit: start/read
// controls and operands in, committed HI/LO, read data and stall out.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             ToLH;
    logic [3:0]       AluOP;
    logic [1:0]       LHToReg;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] LHOut;
    logic             Busy;
    logic             Stall;

    modport master (
        output ToLH, AluOP, LHToReg, A, B,
        input  HI, LO, LHOut, Busy, Stall
    );

    modport slave (
        input  ToLH, AluOP, LHToReg, A, B,
        output HI, LO, LHOut, Busy, Stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit with architectural HI/LO registers.
// One bit per cycle for WIDTH cycles; HI/LO update atomically on the final edge.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    hilo_muldiv_if.slave   bus
);
    localparam logic [3:0]       OP_MULTU = 4'b0011;
    localparam logic [3:0]       OP_DIVU  = 4'b0100;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;

    // Multiply: add multiplicand into the upper half, then shift the whole
    // accumulator right; after WIDTH steps it holds the full product.
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_next_d;

    // Divide: a_q shifts dividend bits out (MSB first) and quotient bits in;
    // the remainder lives in the low half of acc_q.
    logic [WIDTH:0]     div_shift_d;
    logic [WIDTH:0]     div_diff_d;
    logic               div_ge_d;
    logic [WIDTH-1:0]   div_rem_d;
    logic [WIDTH-1:0]   div_quot_d;

    always_comb begin
        mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_next_d  = {mul_sum_d, acc_q[WIDTH-1:1]};

        div_shift_d = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, b_q};
        // A zero divisor always "fits", giving an all-ones quotient and the
        // dividend as remainder.
        div_ge_d    = ~div_diff_d[WIDTH];
        div_rem_d   = div_ge_d ? div_diff_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0];
        div_quot_d  = {a_q[WIDTH-2:0], div_ge_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ToLH && (bus.AluOP == OP_MULTU || bus.AluOP == OP_DIVU)) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (bus.AluOP == OP_MULTU) ? S_MUL : S_DIV;
                    end
                end
                S_MUL: begin
                    acc_q <= mul_next_d;
                    b_q   <= b_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= mul_next_d[2*WIDTH-1:WIDTH];
                        lo_q    <= mul_next_d[WIDTH-1:0];
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    acc_q[WIDTH-1:0] <= div_rem_d;
                    a_q              <= div_quot_d;
                    if (cnt_q == CNT_LAST) begin
                        hi_q    <= div_rem_d;
                        lo_q    <= div_quot_d;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.Busy  = busy_q;
    assign bus.LHOut = (bus.LHToReg == 2'b01) ? lo_q :
                       (bus.LHToReg == 2'b10) ? hi_q : '0;
    assign bus.Stall = busy_q & (bus.ToLH | (bus.LHToReg != 2'b00));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: stimulus pushes expected HI/LO into a
// queue; a monitor pops and checks whenever Busy falls (a commit).
module tb_hilo_muldiv_unit;
    localparam int W = 32;
    localparam logic [3:0] MULTU = 4'b0011;
    localparam logic [3:0] DIVU  = 4'b0100;

    logic clk;
    logic rst_n;
    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Scoreboard monitor: a Busy 1->0 transition while out of reset is a commit.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (rst_n && busy_prev && !bus.Busy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_commit", bus.LO, bus.LO ^ 32'h1);
            end else begin
                e = exp_q.pop_front();
                chk("commit_HI", bus.HI, e[2*W-1:W]);
                chk("commit_LO", bus.LO, e[W-1:0]);
            end
        end
        busy_prev <= bus.Busy;
    end

    // Present an op for one clock (driven at a negedge), optionally logging
    // its expected result. Returns at the following negedge.
    task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        bus.ToLH  = 1'b1;
        bus.AluOP = op;
        bus.A     = a;
        bus.B     = b;
        if (push) exp_q.push_back({ehi, elo});
        @(negedge clk);
        bus.ToLH  = 1'b0;
        bus.AluOP = 4'b0000;
    endtask

    // Counts negedges with Busy high (including the current one).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.Busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        if (cycles >= 200) begin
            total++;
            bad++;
            $display("FAIL wait_idle: timeout after %0d cycles, required Busy=0", cycles);
        end
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        bus.ToLH    = 1'b0;
        bus.AluOP   = 4'b0000;
        bus.LHToReg = 2'b00;
        bus.A       = '0;
        bus.B       = '0;
        repeat (2) @(negedge clk);
        chk("reset_HI", bus.HI, 32'h0);
        chk("reset_LO", bus.LO, 32'h0);
        chk("reset_Busy", {31'b0, bus.Busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Largest product; Busy must be high for exactly WIDTH cycles.
        start_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_idle(n);
        chk("mul_busy_cycles", n, 32);

        start_op(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);
        wait_idle(n);
        chk("div_busy_cycles", n, 32);

        start_op(DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF);
        wait_idle(n);

        // A start while busy is ignored and stalls; HI/LO stay unchanged mid-op.
        start_op(MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12);
        repeat (8) @(negedge clk);
        bus.ToLH  = 1'b1;
        bus.AluOP = DIVU;
        bus.A     = 32'd9;
        bus.B     = 32'd3;
        #1;
        chk("stall_on_tolh", {31'b0, bus.Stall}, 32'h1);
        chk("midop_HI", bus.HI, 32'd5);
        chk("midop_LO", bus.LO, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.ToLH  = 1'b0;
        bus.AluOP = 4'b0000;
        wait_idle(n);
        start_op(DIVU, 32'd9, 32'd3, 1, 32'd0, 32'd3);
        wait_idle(n);

        // MFLO while busy stalls and shows the old committed LO.
        start_op(MULTU, 32'h1234, 32'd1, 1, 32'd0, 32'h1234);
        wait_idle(n);
        start_op(MULTU, 32'd2, 32'd2, 1, 32'd0, 32'd4);
        bus.LHToReg = 2'b01;
        #1;
        chk("mflo_busy_stall", {31'b0, bus.Stall}, 32'h1);
        chk("mflo_busy_lhout", bus.LHOut, 32'h1234);
        wait_idle(n);
        chk("mflo_done_lhout", bus.LHOut, 32'd4);
        chk("mflo_done_stall", {31'b0, bus.Stall}, 32'h0);
        bus.LHToReg = 2'b10;
        #1;
        chk("mfhi_lhout", bus.LHOut, 32'd0);
        bus.LHToReg = 2'b00;
        @(negedge clk);

        // Asynchronous reset mid-divide: nothing committed, no expectation pushed.
        start_op(DIVU, 32'hDEAD_BEEF, 32'h10, 0, 32'd0, 32'd0);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_Busy", {31'b0, bus.Busy}, 32'h0);
        chk("async_rst_HI", bus.HI, 32'h0);
        chk("async_rst_LO", bus.LO, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42);
        wait_idle(n);

        // Unknown AluOP with ToLH: no start, HI/LO unchanged.
        start_op(4'b0000, 32'd11, 32'd13, 0, 32'd0, 32'd0);
        chk("badop_Busy", {31'b0, bus.Busy}, 32'h0);
        chk("badop_HI", bus.HI, 32'd0);
        chk("badop_LO", bus.LO, 32'd42);
        @(negedge clk);
        chk("badop_Busy_later", {31'b0, bus.Busy}, 32'h0);

        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
